seg7_scan_driver: RTL and testbench

//  Time-multiplexed driver for the board's common-anode 8-digit 7-seg display.
//  - Takes a full frame of per-digit segment patterns (active-low, bit order a..g,dp) from the number-to-7seg converters.
//  - Scans the digits one at a time, driving the shared segment bus and one anode line.
//  - Inserts a blanking gap between digits to stop ghosting.
//  - Buffers one pending frame behind a valid/ready handshake and swaps it in only at frame boundaries.

---
 rtl/seg7_scan_driver_pkg.sv | 21 ++
 rtl/seg7_scan_driver_if.sv | 26 ++
 rtl/seg7_scan_driver_timer.sv | 58 +++++
 rtl/seg7_scan_driver.sv | 133 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the scanned 7-segment display drivers.
// Segment patterns are active-low, bit 7 = a ... bit 1 = g, bit 0 = dp.
package seg7_scan_driver_pkg;

    localparam logic [7:0] SEG7_OFF = 8'hFF;

    // Slot phase encodings produced by the scan timer
    localparam logic PH_BLANK = 1'b0;
    localparam logic PH_SHOW  = 1'b1;

    // Hex digit patterns 0..F, decimal point off
    localparam logic [7:0] SEG7_HEX [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    function automatic logic [7:0] seg7_hex(input logic [3:0] value);
        return SEG7_HEX[value];
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Frame handshake between a pattern source and the scan driver.
// master = frame source, slave = seg7_scan_driver.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 8
) ();

    logic                  frame_valid;
    logic                  frame_ready;
    logic [8*DIGITS-1:0]   frame_seg;
    logic [DIGITS-1:0]     frame_en;

    modport master (
        output frame_valid,
        output frame_seg,
        output frame_en,
        input  frame_ready
    );

    modport slave (
        input  frame_valid,
        input  frame_seg,
        input  frame_en,
        output frame_ready
    );

endinterface

// File: rtl/seg7_scan_driver_timer.sv
// seg7_scan_timer: slot counter and digit index for scanned displays.
// idx and phase describe the slot position the NEXT cycle will be in, so a
// consumer can register its outputs and still line up with the counter.
// boundary is high in the last cycle of the last digit's slot.
module seg7_scan_timer
    import seg7_scan_driver_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int IDX_W        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [IDX_W-1:0] idx,
    output logic             phase,
    output logic             boundary
);

    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_nxt;
    logic             last_slot;
    logic             last_digit;

    assign last_slot  = (cnt_q == CNT_W'(TICK_DIV - 1));
    assign last_digit = (idx_q == IDX_W'(DIGITS - 1));

    // Next slot position; reset folds in here so look-ahead outputs are clean
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        cnt_nxt  = cnt_q + CNT_W'(1);
        idx_nxt  = idx_q;
        boundary = 1'b0;
        if (rst) begin
            cnt_nxt = '0;
            idx_nxt = '0;
        end else if (last_slot) begin
            cnt_nxt  = '0;
            idx_nxt  = last_digit ? '0 : idx_q + IDX_W'(1);
            boundary = last_digit;
        end
    end

    assign idx   = idx_nxt;
    assign phase = (cnt_nxt < CNT_W'(BLANK_CYCLES)) ? PH_BLANK : PH_SHOW;

    // Slot counter and digit index registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        cnt_q <= cnt_nxt;
        idx_q <= idx_nxt;
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a common-anode multi-digit
// 7-segment display with per-digit blanking and a one-deep frame buffer.
// Optional feature macro: SEG7_BRIGHTNESS_EN adds a 4-bit PWM brightness input.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_driver_if.slave   bus,
`ifdef SEG7_BRIGHTNESS_EN
    input  logic [3:0]          brightness,
`endif
    output logic [DIGITS-1:0]   an,
    output logic [0:7]          seg,
    output logic                frame_tick
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [IDX_W-1:0]    idx;
    logic                phase;
    logic                boundary;

    logic                pend_full;
    logic [8*DIGITS-1:0] pend_seg;
    logic [DIGITS-1:0]   pend_en;
    logic [8*DIGITS-1:0] act_seg;
    logic [DIGITS-1:0]   act_en;
    logic [8*DIGITS-1:0] act_seg_nxt;
    logic [DIGITS-1:0]   act_en_nxt;
    logic                accept;
    logic                swap;
    logic                lit;
    logic [DIGITS-1:0]   an_d;
    logic [7:0]          seg_d;

    seg7_scan_timer #(
        .DIGITS       (DIGITS),
        .TICK_DIV     (TICK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .IDX_W        (IDX_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .idx      (idx),
        .phase    (phase),
        .boundary (boundary)
    );

    assign bus.frame_ready = !pend_full;
    assign accept          = bus.frame_valid && !pend_full;
    assign swap            = boundary && pend_full;

    // Pending-slot occupancy: filled on accept, emptied at the frame boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_full <= 1'b0;
        end else if (swap) begin
            pend_full <= 1'b0;
        end else if (accept) begin
            pend_full <= 1'b1;
        end
    end

    // Pending frame data; meaningless while pend_full is low
    always_ff @(posedge clk) begin
        // NOTE: pure data registers qualified by a valid flag are left without reset.
        if (accept) begin
            pend_seg <= bus.frame_seg;
            pend_en  <= bus.frame_en;
        end
    end

    // Active frame, replaced only at a frame boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            act_seg <= {DIGITS{SEG7_OFF}};
            act_en  <= '0;
        end else if (swap) begin
            act_seg <= pend_seg;
            act_en  <= pend_en;
        end
    end

    assign act_seg_nxt = swap ? pend_seg : act_seg;
    assign act_en_nxt  = swap ? pend_en  : act_en;

`ifdef SEG7_BRIGHTNESS_EN
    logic [3:0] pwm_cnt;
    logic [3:0] pwm_nxt;

    assign pwm_nxt = rst ? 4'd0 : pwm_cnt + 4'd1;

    // Free-running PWM phase counter
    always_ff @(posedge clk) begin
        pwm_cnt <= pwm_nxt;
    end
`endif

    // Output decode for the coming cycle; one-hot anode by construction
    always_comb begin
        an_d  = '1;
        seg_d = SEG7_OFF;
        lit   = 1'b0;
        if (phase == PH_SHOW) begin
            seg_d = act_seg_nxt[8*idx +: 8];
`ifdef SEG7_BRIGHTNESS_EN
            lit   = act_en_nxt[idx] && (pwm_nxt < brightness);
`else
            lit   = act_en_nxt[idx];
`endif
            an_d[idx] = !lit;
        end
    end

    // Registered display outputs and frame tick
    always_ff @(posedge clk) begin
        if (rst) begin
            an         <= '1;
            seg        <= SEG7_OFF;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_d;
            seg        <= seg_d;
            frame_tick <= boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver. A cycle-count reference model
// derives the expected display from absolute time since reset and a
// transaction-level view of the pending/active frames.
module tb_seg7_scan_driver;
    import seg7_scan_driver_pkg::*;

    localparam int DIGITS = 8;
`ifdef SEG7_BRIGHTNESS_EN
    localparam int TICK_DIV = 40;
    localparam int BLANK    = 4;
`else
    localparam int TICK_DIV = 10;
    localparam int BLANK    = 2;
`endif
    localparam int FRAME = DIGITS * TICK_DIV;
    localparam int EW    = DIGITS + 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [DIGITS-1:0] an;
    logic [0:7]        seg;
    logic              frame_tick;
`ifdef SEG7_BRIGHTNESS_EN
    logic [3:0]        brightness;
`endif

    seg7_scan_driver_if #(.DIGITS(DIGITS)) bus ();

    seg7_scan_driver #(
        .DIGITS       (DIGITS),
        .TICK_DIV     (TICK_DIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
`ifdef SEG7_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Reference model state
    int                  t;
    logic [8*DIGITS-1:0] m_act_seg;
    logic [DIGITS-1:0]   m_act_en;
    logic [8*DIGITS-1:0] m_pend_seg;
    logic [DIGITS-1:0]   m_pend_en;
    bit                  m_pend_full;
    bit                  m_acc;

    int checks   = 0;
    int failures = 0;

    // Advance the model by the rules of one clock edge, then the clock itself
    task automatic step();
        m_acc = 1'b0;
        if (rst) begin
            t           = 0;
            m_act_seg   = '1;
            m_act_en    = '0;
            m_pend_full = 1'b0;
        end else begin
            if ((t % FRAME) == FRAME - 1 && m_pend_full) begin
                m_act_seg   = m_pend_seg;
                m_act_en    = m_pend_en;
                m_pend_full = 1'b0;
            end else if (bus.frame_valid && !m_pend_full) begin
                m_pend_seg  = bus.frame_seg;
                m_pend_en   = bus.frame_en;
                m_pend_full = 1'b1;
                m_acc       = 1'b1;
            end
            t++;
        end
        @(posedge clk);
        #1;
    endtask

    // Expected {an, seg, frame_tick, frame_ready} for the current model time
    function automatic logic [EW-1:0] exp_vec();
        logic [DIGITS-1:0] a;
        logic [7:0]        s;
        int                c;
        int                i;
        bit                on;
        a = '1;
        s = 8'hFF;
        c = t % TICK_DIV;
        i = (t / TICK_DIV) % DIGITS;
        if (c >= BLANK) begin
            s  = m_act_seg[8*i +: 8];
            on = m_act_en[i];
`ifdef SEG7_BRIGHTNESS_EN
            on = on && ((t % 16) < int'(brightness));
`endif
            if (on) a[i] = 1'b0;
        end
        return {a, s, (t > 0) && (t % FRAME == 0), !m_pend_full};
    endfunction

    function automatic logic [8*DIGITS-1:0] rand_frame();
        logic [8*DIGITS-1:0] f;
        for (int d = 0; d < DIGITS; d++)
            f[8*d +: 8] = seg7_hex(4'($urandom_range(15))) & {7'h7F, 1'($urandom)};
        return f;
    endfunction

    task automatic test_reset();
        logic [EW-1:0] obs;
        rst             = 1'b1;
        bus.frame_valid = 1'b0;
        bus.frame_seg   = '0;
        bus.frame_en    = '0;
        repeat (3) begin
            step();
            obs = {an, seg, frame_tick, bus.frame_ready};
            checks++;
            if (obs !== {{DIGITS{1'b1}}, 8'hFF, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL reset: got %h expected %h", obs, {{DIGITS{1'b1}}, 8'hFF, 1'b0, 1'b1});
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_frame_load();
        logic [EW-1:0]       obs;
        logic [EW-1:0]       exp;
        logic [8*DIGITS-1:0] f;
        f        = rand_frame();
        f[7:0]   = 8'b00000011;
        f[15:8]  = 8'b10011111;
        bus.frame_seg   = f;
        bus.frame_en    = 8'h03;
        bus.frame_valid = 1'b1;
        while (t < FRAME + 2 * TICK_DIV) begin
            step();
            if (m_acc) bus.frame_valid = 1'b0;
            obs = {an, seg, frame_tick, bus.frame_ready};
            exp = exp_vec();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL frame_load t=%0d: got %h expected %h", t, obs, exp);
            end
            if (t == FRAME) begin
                checks++;
                if (frame_tick !== 1'b1) begin
                    failures++;
                    $display("FAIL frame_tick_at_frame t=%0d: got %b expected 1", t, frame_tick);
                end
            end
            if (t == FRAME + BLANK || t == FRAME + TICK_DIV + BLANK) begin
                checks++;
                if (t == FRAME + BLANK && {an, seg} !== {8'hFE, 8'b00000011}) begin
                    failures++;
                    $display("FAIL digit0_show: got an=%h seg=%b expected an=fe seg=00000011", an, seg);
                end else if (t == FRAME + TICK_DIV + BLANK && {an, seg} !== {8'hFD, 8'b10011111}) begin
                    failures++;
                    $display("FAIL digit1_show: got an=%h seg=%b expected an=fd seg=10011111", an, seg);
                end
            end
        end
    endtask

    task automatic test_disabled_digit();
        logic [EW-1:0] obs;
        logic [EW-1:0] exp;
        int            stop;
        stop            = (t / FRAME + 2) * FRAME;
        bus.frame_seg   = rand_frame();
        bus.frame_en    = 8'hFB;
        bus.frame_valid = 1'b1;
        while (t < stop) begin
            step();
            if (m_acc) bus.frame_valid = 1'b0;
            obs = {an, seg, frame_tick, bus.frame_ready};
            exp = exp_vec();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL disabled_digit t=%0d: got %h expected %h", t, obs, exp);
            end
            if (t >= stop - FRAME && (t % FRAME) / TICK_DIV == 2) begin
                checks++;
                if (an !== '1) begin
                    failures++;
                    $display("FAIL digit2_dark t=%0d: got an=%h expected ff", t, an);
                end
            end
        end
    endtask

    task automatic offer(input logic [8*DIGITS-1:0] f, input logic [DIGITS-1:0] en,
                         input string name, output bit tick_at_accept);
        logic [EW-1:0] obs;
        logic [EW-1:0] exp;
        bit            tick_before;
        int            budget;
        budget          = 3 * FRAME;
        bus.frame_seg   = f;
        bus.frame_en    = en;
        bus.frame_valid = 1'b1;
        tick_at_accept  = 1'b0;
        while (bus.frame_valid) begin
            tick_before = frame_tick;
            step();
            obs = {an, seg, frame_tick, bus.frame_ready};
            exp = exp_vec();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL %s t=%0d: got %h expected %h", name, t, obs, exp);
            end
            if (m_acc) begin
                bus.frame_valid = 1'b0;
                tick_at_accept  = tick_before;
            end
            budget--;
            if (budget == 0 && bus.frame_valid) begin
                checks++;
                failures++;
                $display("FAIL %s_timeout: got no accept expected accept", name);
                bus.frame_valid = 1'b0;
            end
        end
    endtask

    task automatic run_cycles(input int n, input string name);
        logic [EW-1:0] obs;
        logic [EW-1:0] exp;
        for (int k = 0; k < n; k++) begin
            step();
            obs = {an, seg, frame_tick, bus.frame_ready};
            exp = exp_vec();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL %s t=%0d: got %h expected %h", name, t, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit tick_acc;
        offer(rand_frame(), 8'($urandom) | 8'h01, "b2b_first", tick_acc);
        checks++;
        if (bus.frame_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ready_low: got %b expected 0", bus.frame_ready);
        end
        offer(rand_frame(), 8'hFF, "b2b_second", tick_acc);
        checks++;
        if (tick_acc !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept_after_boundary: got tick=%b expected 1", tick_acc);
        end
        run_cycles(2 * FRAME, "b2b_display");
    endtask

    task automatic test_random();
        logic [EW-1:0] obs;
        logic [EW-1:0] exp;
        for (int k = 0; k < 5 * FRAME; k++) begin
            if (!bus.frame_valid && $urandom_range(7) == 0) begin
                bus.frame_seg   = rand_frame();
                bus.frame_en    = 8'($urandom);
                bus.frame_valid = 1'b1;
            end
            step();
            if (m_acc) bus.frame_valid = 1'b0;
            obs = {an, seg, frame_tick, bus.frame_ready};
            exp = exp_vec();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL random t=%0d: got %h expected %h", t, obs, exp);
            end
        end
        bus.frame_valid = 1'b0;
    endtask

    task automatic test_reset_mid_show();
        logic [EW-1:0] obs;
        int            budget;
        int            lit_cycles;
        budget          = 2 * FRAME;
        bus.frame_seg   = rand_frame();
        bus.frame_en    = 8'hFF;
        bus.frame_valid = 1'b1;
        while ((t % FRAME) != 5 * TICK_DIV + BLANK + 3 && budget > 0) begin
            step();
            if (m_acc) bus.frame_valid = 1'b0;
            budget--;
        end
        bus.frame_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        obs = {an, seg, frame_tick, bus.frame_ready};
        checks++;
        if (obs !== {{DIGITS{1'b1}}, 8'hFF, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_mid_show: got %h expected %h", obs, {{DIGITS{1'b1}}, 8'hFF, 1'b0, 1'b1});
        end
        lit_cycles = 0;
        for (int k = 0; k < FRAME + TICK_DIV; k++) begin
            step();
            if (an !== '1) lit_cycles++;
        end
        checks++;
        if (lit_cycles != 0) begin
            failures++;
            $display("FAIL reset_blank_frame: got %0d lit cycles expected 0", lit_cycles);
        end
    endtask

`ifdef SEG7_BRIGHTNESS_EN
    task automatic test_brightness();
        bit tick_acc;
        int lit_cycles;
        brightness = 4'd4;
        offer(rand_frame(), 8'hFF, "bright4_load", tick_acc);
        run_cycles(2 * FRAME, "bright4");
        brightness = 4'd0;
        lit_cycles = 0;
        for (int k = 0; k < FRAME; k++) begin
            step();
            if (an !== '1) lit_cycles++;
        end
        checks++;
        if (lit_cycles != 0) begin
            failures++;
            $display("FAIL bright0_dark: got %0d lit cycles expected 0", lit_cycles);
        end
        brightness = 4'd15;
    endtask
`endif

    initial begin
`ifdef SEG7_BRIGHTNESS_EN
        brightness = 4'd15;
`endif
        test_reset();
        test_frame_load();
        test_disabled_digit();
        test_back_to_back();
        test_random();
        test_reset_mid_show();
`ifdef SEG7_BRIGHTNESS_EN
        test_brightness();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
